multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle sequencer for the 16-bit processor datapath, replacing the single-cycle "everything every clock" control. It fetches each instruction from instruction memory with a req/ack handshake and latches it. It then steps through DECODE, EXECUTE and WRITEBACK, producing register-file write, ALU operand-select and program-counter strobes. It also counts retired instructions and traps fetch timeouts.

## Interface
- `FETCH_TIMEOUT`, default 16: the maximum number of FETCH cycles without `imem_ack`. A value of 0 disables the timeout.
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  level input. Leaves IDLE or HALT and begins fetching.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_ack`  in  1  instruction valid on `instr` this cycle.
- `instr`  in  16  fetched instruction word.
- `ir_load`  out  1  instruction-register capture strobe.
- `opcode`  out  3  registered `instr[15:13]` of the current instruction.
- `alu_b_imm`  out  1  ALU B operand select: 1 selects the zero-extended `instr[3:0]`, 0 selects the register.
- `rf_we`  out  1  register-file write enable.
- `eq_in`  in  1  BEQ compare result from the datapath (rd == rs1).
- `pc_inc`  out  1  PC +1 strobe.
- `pc_branch`  out  1  PC load-branch-target strobe.
- `busy`  out  1  high in FETCH, DECODE, EXECUTE and WRITEBACK.
- `halted`  out  1  high in HALT.
- `error`  out  1  high in ERROR.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT, ERROR. Encoding comes from the package.
- Opcodes:
  - 000 ADD, 001 ADDI, 010 SUBI are ALU ops.
  - 011 is BEQ.
  - 111 is HALT.
  - 100–110 are NOP.
- IDLE: when `start`=1, go to FETCH.
- FETCH:
  - `imem_req`=1 in every FETCH cycle.
  - `ir_load`=`imem_ack`. This output is Mealy, valid only in FETCH.
  - When `imem_ack`=1, capture `instr` and go to DECODE.
  - Otherwise increment the wait counter. If FETCH_TIMEOUT≠0 and FETCH_TIMEOUT cycles have passed with no ack, go to ERROR.
  - The wait counter clears when FETCH is entered.
- DECODE: `opcode` is updated from the captured instruction. Go to EXECUTE.
- EXECUTE:
  - ALU op: go to WRITEBACK. For ADDI and SUBI, `alu_b_imm`=1 during both EXECUTE and WRITEBACK.
  - BEQ: sample `eq_in`. If it is 1, `pc_branch`=1; otherwise `pc_inc`=1. Go to FETCH.
  - NOP: `pc_inc`=1, go to FETCH.
  - HALT: `pc_inc`=1, go to HALT.
- WRITEBACK: `rf_we`=1 and `pc_inc`=1, then go to FETCH.
- HALT: when `start`=1, go to FETCH. Otherwise hold.
- ERROR: sticky. Only reset exits it.
- Strobe rules:
  - `rf_we`, `pc_inc` and `pc_branch` are single-cycle Moore outputs decoded from state plus the captured opcode.
  - At most one of `pc_inc` and `pc_branch` is high in any cycle.
- `retired` increments in every cycle where `pc_inc` or `pc_branch` is high. It wraps from all-ones to 0.
- `imem_ack` is ignored outside FETCH. `start` is ignored outside IDLE and HALT.

## Timing
- Reset (asynchronous assert):
  - State goes to IDLE.
  - `opcode`, the instruction register, the wait counter and `retired` clear to 0.
  - All strobes, `busy`, `halted` and `error` are 0.
  - Release is synchronous to `clk`.
- Reset asserted mid-instruction aborts it without a write or PC update in that cycle.
- CPI with a zero-wait ack (ack in the first FETCH cycle):
  - ALU op: 4 cycles.
  - BEQ, NOP and HALT: 3 cycles.
  - Each wait cycle adds 1.
- `start` high in IDLE gives `imem_req` high on the next cycle.
- Timeout boundary:
  - An ack in FETCH cycle N=FETCH_TIMEOUT is accepted.
  - No ack by the end of cycle N means ERROR on the next edge, with `error`=1 that cycle.
- `retired` is visible one cycle after its strobe.

## Structure
- Package `proc_ctrl_pkg`:
  - opcode constants OP_ADD, OP_ADDI, OP_SUBI, OP_BEQ, OP_HALT;
  - the state enum typedef;
  - the instruction field slice constants.
- Optional sub-module `fetch_watchdog`: the wait counter plus timeout compare, parameterised by FETCH_TIMEOUT. Everything else stays in one FSM module.

## Test plan
- **ADD with ack in the first cycle.** Program word 16'h0503, `start` pulsed.
  - FETCH/DECODE/EXECUTE/WRITEBACK take 4 cycles.
  - `rf_we` and `pc_inc` are high together in cycle 4.
  - `retired`=1.
- **ADDI with 3 wait cycles.** Word 16'h2085.
  - `imem_req` is high for 4 cycles and `ir_load` pulses in cycle 4.
  - `alu_b_imm`=1 in EXECUTE and WRITEBACK.
  - The total is 7 cycles.
- **BEQ taken, then not taken.**
  - With `eq_in`=1: `pc_branch` pulses in EXECUTE and `pc_inc`=0.
  - With `eq_in`=0: `pc_inc` pulses instead.
  - Each takes 3 cycles, and `retired` advances by 2 in total.
- **HALT (16'hE000).**
  - `pc_inc` pulses, then `halted`=1 and `busy`=0. `start` held low keeps it halted.
  - `start`=1 causes FETCH on the next cycle.
- **Timeout with FETCH_TIMEOUT=4.**
  - Ack never arrives: `error`=1 after exactly 4 FETCH cycles and stays 1, even with `start` and `imem_ack` toggling.
  - An ack in cycle 4 is accepted with no error.
- **Reset during WRITEBACK.**
  - All outputs are 0 and `retired`=0 immediately, with no `rf_we` pulse.
  - After release, state is IDLE and waiting for `start`.
- **Counter wrap.** Preload or run with `CNT_W`=4: 16 retirements wrap `retired` back to 0.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared opcode, state and instruction-field definitions for the multi-cycle controller.
// Pure definitions: no latency, no flow control.
package proc_ctrl_pkg;

  localparam int INSTR_W = 16;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef logic [OP_MSB-OP_LSB:0] opcode_t;

  localparam opcode_t OP_ADD  = 3'b000;
  localparam opcode_t OP_ADDI = 3'b001;
  localparam opcode_t OP_SUBI = 3'b010;
  localparam opcode_t OP_BEQ  = 3'b011;
  localparam opcode_t OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  function automatic logic is_alu(input opcode_t op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

  function automatic logic is_imm(input opcode_t op);
    return (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-memory fetch bus: request from the controller, ack plus word from memory.
// Memory may hold off ack for any number of cycles; the controller keeps req high meanwhile.
interface multicycle_controller_if;
  import proc_ctrl_pkg::*;

  logic               imem_req;
  logic               imem_ack;
  logic [INSTR_W-1:0] instr;

  modport master (output imem_req, input imem_ack, input instr);
  modport slave  (input imem_req, output imem_ack, output instr);

endinterface

// File: rtl/fetch_watchdog.sv
// Counts FETCH cycles without ack and flags the last permitted one; FETCH_TIMEOUT=0 disables.
// expired is combinational from the count, so the FSM leaves on the edge ending cycle N.
module fetch_watchdog #(
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic ack,
  output logic expired
);

  localparam int W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  localparam logic [W-1:0] LAST = W'((FETCH_TIMEOUT == 0) ? 0 : FETCH_TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Held at zero outside FETCH, so every FETCH entry starts from a clean count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (!ack) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (FETCH_TIMEOUT != 0) && run && !ack && (cnt == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with retired counter and fetch timeout.
// CPI 4 for ALU ops, 3 otherwise, +1 per fetch wait cycle; fetch stalls until imem_ack.
module multicycle_controller
  import proc_ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master imem,
  input  logic                   start,
  output logic                   ir_load,
  output opcode_t                opcode,
  output logic                   alu_b_imm,
  output logic                   rf_we,
  input  logic                   eq_in,
  output logic                   pc_inc,
  output logic                   pc_branch,
  output logic                   busy,
  output logic                   halted,
  output logic                   error,
  output logic [CNT_W-1:0]       retired
);

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic               req_q;
  logic               in_fetch;
  logic               wd_expired;
  opcode_t            ir_op;
  logic               ir_unused;

  assign in_fetch      = (state == ST_FETCH);
  assign ir_op         = ir[OP_MSB:OP_LSB];
  assign ir_unused     = ^ir[OP_LSB-1:0];
  assign imem.imem_req = req_q;
  assign ir_load       = in_fetch && imem.imem_ack;

  fetch_watchdog #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .run    (in_fetch),
    .ack    (imem.imem_ack),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ir        <= '0;
      opcode    <= '0;
      req_q     <= 1'b0;
      alu_b_imm <= 1'b0;
      rf_we     <= 1'b0;
      pc_inc    <= 1'b0;
      pc_branch <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      error     <= 1'b0;
    end else begin
      rf_we     <= 1'b0;
      pc_inc    <= 1'b0;
      pc_branch <= 1'b0;
      unique case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state  <= ST_FETCH;
            req_q  <= 1'b1;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (imem.imem_ack) begin
            ir    <= imem.instr;
            req_q <= 1'b0;
            state <= ST_DECODE;
          end else if (wd_expired) begin
            state <= ST_ERROR;
            req_q <= 1'b0;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        ST_DECODE: begin
          // EXECUTE strobes are prepared here so they are clean flops during EXECUTE;
          // eq_in is taken once the operands have been read out in DECODE.
          opcode    <= ir_op;
          alu_b_imm <= is_imm(ir_op);
          state     <= ST_EXECUTE;
          if (ir_op == OP_BEQ) begin
            pc_branch <= eq_in;
            pc_inc    <= !eq_in;
          end else if (!is_alu(ir_op)) begin
            pc_inc <= 1'b1;
          end
        end
        ST_EXECUTE: begin
          if (is_alu(opcode)) begin
            state  <= ST_WRITEBACK;
            rf_we  <= 1'b1;
            pc_inc <= 1'b1;
          end else if (opcode == OP_HALT) begin
            state     <= ST_HALT;
            busy      <= 1'b0;
            halted    <= 1'b1;
            alu_b_imm <= 1'b0;
          end else begin
            state     <= ST_FETCH;
            req_q     <= 1'b1;
            alu_b_imm <= 1'b0;
          end
        end
        ST_WRITEBACK: begin
          state     <= ST_FETCH;
          req_q     <= 1'b1;
          alu_b_imm <= 1'b0;
        end
        ST_ERROR: begin
        end
        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (pc_inc || pc_branch) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction expected traces from a reference model.
// Runs with FETCH_TIMEOUT=4 and a 4-bit retired counter to reach timeout and wrap boundaries.
module tb_multicycle_controller;

  localparam int FT = 4;
  localparam int CW = 4;

  // Output vector bit order: req, ir_load, rf_we, pc_inc, pc_branch, alu_b_imm, busy, halted, error
  localparam logic [8:0] O_IDLE  = 9'b000000000;
  localparam logic [8:0] O_FETCH = 9'b100000100;
  localparam logic [8:0] O_HALT  = 9'b000000010;
  localparam logic [8:0] O_ERR   = 9'b000000001;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          eq_in = 1'b0;
  logic          ir_load, alu_b_imm, rf_we, pc_inc, pc_branch, busy, halted, error;
  logic [2:0]    opcode;
  logic [CW-1:0] retired;

  multicycle_controller_if bus();

  multicycle_controller #(
    .FETCH_TIMEOUT(FT),
    .CNT_W        (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .imem     (bus),
    .start    (start),
    .ir_load  (ir_load),
    .opcode   (opcode),
    .alu_b_imm(alu_b_imm),
    .rf_we    (rf_we),
    .eq_in    (eq_in),
    .pc_inc   (pc_inc),
    .pc_branch(pc_branch),
    .busy     (busy),
    .halted   (halted),
    .error    (error),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]    outs;
    logic [CW-1:0] ret;
    logic [2:0]    op;
  } obs_t;

  typedef struct {
    bit            ack;
    logic [8:0]    outs;
    logic [CW-1:0] ret;
    bit            op_chk;
    logic [2:0]    op;
    logic [15:0]   w;
    logic          eq;
  } exp_t;

  exp_t exp_q[$];
  int   mdl_ret = 0;
  int   checks  = 0;
  int   errors  = 0;

  function automatic void push(bit ack, logic [8:0] outs, bit op_chk, logic [2:0] op,
                               logic [15:0] w, logic eq);
    exp_t r;
    r.ack = ack; r.outs = outs; r.ret = CW'(mdl_ret);
    r.op_chk = op_chk; r.op = op; r.w = w; r.eq = eq;
    exp_q.push_back(r);
  endfunction

  // One instruction, starting at its first FETCH cycle, as the cycle-by-cycle outputs it should produce.
  function automatic void model_instr(logic [15:0] w, int waits, logic eq);
    logic [2:0] op;
    bit alu, imm, take;
    op   = w[15:13];
    alu  = (op <= 3'd2);
    imm  = (op == 3'd1) || (op == 3'd2);
    take = (op == 3'd3) && eq;
    for (int c = 0; c <= waits; c++)
      push(c == waits, {1'b1, (c == waits), 7'b0000100}, 1'b0, 3'd0, w, eq);
    push(1'b0, 9'b000000100, 1'b0, 3'd0, w, eq);
    push(1'b0, {3'b000, (!alu && !take), take, imm, 3'b100}, 1'b1, op, w, eq);
    if (alu) begin
      push(1'b0, {3'b001, 1'b1, 1'b0, imm, 3'b100}, 1'b1, op, w, eq);
    end
    mdl_ret = (mdl_ret + 1) % (1 << CW);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.outs = {bus.imem_req, ir_load, rf_we, pc_inc, pc_branch, alu_b_imm, busy, halted, error};
    o.ret  = retired;
    o.op   = opcode;
    return o;
  endfunction

  task automatic cycle(input logic ack, input logic [15:0] w, input logic eq, input logic st,
                       output obs_t o);
    bus.imem_ack = ack;
    bus.instr    = w;
    eq_in        = eq;
    start        = st;
    #2;
    o = sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o;
    #2 reset = 1'b0;
    #1;
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_async: got %h, expected 0", o);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle(1'($urandom), 16'($urandom), 1'($urandom), 1'b0, o);
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_idle %0d: got %h, expected 0", i, o);
      end
    end
  endtask

  task automatic test_add();
    obs_t o;
    exp_t r;
    cycle(1'($urandom), 16'($urandom), 1'($urandom), 1'b1, o);
    checks++;
    if (o.outs !== O_IDLE) begin
      errors++;
      $display("FAIL add_start_cycle: outs=%b expected %b", o.outs, O_IDLE);
    end
    model_instr(16'h0503, 0, 1'($urandom));
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      cycle(r.outs[8] ? r.ack : 1'($urandom), r.ack ? r.w : 16'($urandom), r.eq, 1'($urandom), o);
      checks++;
      if (o.outs !== r.outs || o.ret !== r.ret || (r.op_chk && o.op !== r.op)) begin
        errors++;
        $display("FAIL add_trace: outs=%b ret=%0d op=%0d expected outs=%b ret=%0d op=%0d",
                 o.outs, o.ret, o.op, r.outs, r.ret, r.op);
      end
    end
  endtask

  task automatic test_addi_wait();
    obs_t o;
    exp_t r;
    model_instr(16'h2085, 3, 1'($urandom));
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      cycle(r.outs[8] ? r.ack : 1'($urandom), r.ack ? r.w : 16'($urandom), r.eq, 1'($urandom), o);
      checks++;
      if (o.outs !== r.outs || o.ret !== r.ret || (r.op_chk && o.op !== r.op)) begin
        errors++;
        $display("FAIL addi_wait_trace: outs=%b ret=%0d op=%0d expected outs=%b ret=%0d op=%0d",
                 o.outs, o.ret, o.op, r.outs, r.ret, r.op);
      end
    end
  endtask

  task automatic test_beq();
    obs_t o;
    exp_t r;
    model_instr({3'b011, 13'($urandom)}, int'($urandom_range(0, 2)), 1'b1);
    model_instr({3'b011, 13'($urandom)}, int'($urandom_range(0, 2)), 1'b0);
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      cycle(r.outs[8] ? r.ack : 1'($urandom), r.ack ? r.w : 16'($urandom), r.eq, 1'($urandom), o);
      checks++;
      if (o.outs !== r.outs || o.ret !== r.ret || (r.op_chk && o.op !== r.op)) begin
        errors++;
        $display("FAIL beq_trace: outs=%b ret=%0d op=%0d expected outs=%b ret=%0d op=%0d",
                 o.outs, o.ret, o.op, r.outs, r.ret, r.op);
      end
    end
  endtask

  task automatic test_halt();
    obs_t o;
    exp_t r;
    model_instr(16'hE000, int'($urandom_range(0, 2)), 1'($urandom));
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      cycle(r.outs[8] ? r.ack : 1'($urandom), r.ack ? r.w : 16'($urandom), r.eq, 1'($urandom), o);
      checks++;
      if (o.outs !== r.outs || o.ret !== r.ret || (r.op_chk && o.op !== r.op)) begin
        errors++;
        $display("FAIL halt_trace: outs=%b ret=%0d op=%0d expected outs=%b ret=%0d op=%0d",
                 o.outs, o.ret, o.op, r.outs, r.ret, r.op);
      end
    end
    for (int i = 0; i < 4; i++) begin
      // Last iteration raises start: still HALT this cycle, FETCH on the next.
      cycle(1'($urandom), 16'($urandom), 1'($urandom), (i == 3), o);
      checks++;
      if (o.outs !== O_HALT || o.ret !== CW'(mdl_ret)) begin
        errors++;
        $display("FAIL halt_hold %0d: outs=%b ret=%0d expected outs=%b ret=%0d",
                 i, o.outs, o.ret, O_HALT, mdl_ret);
      end
    end
    model_instr({3'b100, 13'($urandom)}, 0, 1'($urandom));
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      cycle(r.outs[8] ? r.ack : 1'($urandom), r.ack ? r.w : 16'($urandom), r.eq, 1'($urandom), o);
      checks++;
      if (o.outs !== r.outs || o.ret !== r.ret || (r.op_chk && o.op !== r.op)) begin
        errors++;
        $display("FAIL halt_restart_trace: outs=%b ret=%0d op=%0d expected outs=%b ret=%0d op=%0d",
                 o.outs, o.ret, o.op, r.outs, r.ret, r.op);
      end
    end
  endtask

  task automatic test_random_wrap();
    obs_t o;
    exp_t r;
    for (int n = 0; n < 18; n++) begin
      model_instr({3'($urandom_range(0, 6)), 13'($urandom)}, int'($urandom_range(0, FT - 1)),
                  1'($urandom));
    end
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      cycle(r.outs[8] ? r.ack : 1'($urandom), r.ack ? r.w : 16'($urandom), r.eq, 1'($urandom), o);
      checks++;
      if (o.outs !== r.outs || o.ret !== r.ret || (r.op_chk && o.op !== r.op)) begin
        errors++;
        $display("FAIL random_wrap_trace: w=%h outs=%b ret=%0d op=%0d expected outs=%b ret=%0d op=%0d",
                 r.w, o.outs, o.ret, o.op, r.outs, r.ret, r.op);
      end
    end
  endtask

  task automatic test_reset_wb();
    obs_t o;
    exp_t r;
    model_instr({3'b000, 13'($urandom)}, int'($urandom_range(0, 2)), 1'($urandom));
    while (exp_q.size() > 1) begin
      r = exp_q.pop_front();
      cycle(r.outs[8] ? r.ack : 1'($urandom), r.ack ? r.w : 16'($urandom), r.eq, 1'($urandom), o);
      checks++;
      if (o.outs !== r.outs || o.ret !== r.ret || (r.op_chk && o.op !== r.op)) begin
        errors++;
        $display("FAIL reset_wb_trace: outs=%b ret=%0d op=%0d expected outs=%b ret=%0d op=%0d",
                 o.outs, o.ret, o.op, r.outs, r.ret, r.op);
      end
    end
    r = exp_q.pop_front();
    bus.imem_ack = 1'($urandom);
    start        = 1'($urandom);
    #1 reset = 1'b0;
    #1;
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_wb_async: got %h expected 0 (writeback outs were %b)", o, r.outs);
    end
    @(posedge clk);
    #1;
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_wb_held: got %h expected 0", o);
    end
    reset   = 1'b1;
    mdl_ret = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'($urandom), 16'($urandom), 1'($urandom), (i == 2), o);
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_wb_idle %0d: got %h expected 0", i, o);
      end
    end
    model_instr({3'b101, 13'($urandom)}, int'($urandom_range(0, 2)), 1'($urandom));
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      cycle(r.outs[8] ? r.ack : 1'($urandom), r.ack ? r.w : 16'($urandom), r.eq, 1'($urandom), o);
      checks++;
      if (o.outs !== r.outs || o.ret !== r.ret || (r.op_chk && o.op !== r.op)) begin
        errors++;
        $display("FAIL reset_wb_restart: outs=%b ret=%0d op=%0d expected outs=%b ret=%0d op=%0d",
                 o.outs, o.ret, o.op, r.outs, r.ret, r.op);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    for (int c = 1; c <= FT; c++) begin
      cycle(1'b0, 16'($urandom), 1'($urandom), 1'($urandom), o);
      checks++;
      if (o.outs !== O_FETCH) begin
        errors++;
        $display("FAIL timeout_wait cycle %0d: outs=%b expected %b", c, o.outs, O_FETCH);
      end
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), o);
      checks++;
      if (o.outs !== O_ERR || o.ret !== CW'(mdl_ret)) begin
        errors++;
        $display("FAIL timeout_error %0d: outs=%b ret=%0d expected outs=%b ret=%0d",
                 i, o.outs, o.ret, O_ERR, mdl_ret);
      end
    end
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.instr    = '0;
    test_reset();
    test_add();
    test_addi_wait();
    test_beq();
    test_halt();
    test_random_wrap();
    test_reset_wb();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_bound: bench did not complete within 100000 time units");
    $fatal(1, "time bound exceeded");
  end

endmodule
